sakupljac_uzorka: RTL and testbench
===================================

// Module: sakupljac_uzorka
// PURPOSE
//   Upstream stage of the first-layer neuron. Collects one sonar sample as a stream of
//   60 16-bit features, one per beat, and presents it as the flat 960-bit uzorak bus.
//   Holds the bus stable with uzorak_valid until the classifier accepts it (out_ready).
//   Feature k lands in uzorak[16k+15:16k], so feature 0 is at [15:0].
// PARAMETERS
//   BROJ_ZNACAJKI    60  features per sample
//   SIRINA_ZNACAJKE  16  bits per feature; unsigned, passed through unmodified
// PORTS
//   clk            in   1     single clock, rising edge
//   rst_n          in   1     asynchronous, active-low reset
//   in_data        in   16    feature value
//   in_valid       in   1     in_data/in_last valid
//   in_last        in   1     marks the final feature of a sample
//   in_ready       out  1     stage accepts a beat
//   uzorak         out  960   assembled sample (= BROJ_ZNACAJKI*SIRINA_ZNACAJKE)
//   uzorak_valid   out  1     uzorak complete and stable
//   out_ready      in   1     downstream consumes uzorak
//   greska         out  1     one-cycle pulse on a framing error
//   broj_uzoraka   out  16    count of samples delivered; wraps 0xFFFF->0
// BEHAVIOUR
//   Reset (async, rst_n=0): state=PRIJEM, brojac=0, uzorak=0, uzorak_valid=0, greska=0,
//     broj_uzoraka=0. A partial sample in progress at reset is lost.
//   Beat: accepted when in_valid && in_ready on a rising clk edge.
//   in_ready = (state==PRIJEM) || (state==ODBACI). Decoded from registered state only;
//     no combinational path from out_ready.
//   State PRIJEM: an accepted beat writes uzorak[brojac*16 +: 16] = in_data.
//     - brojac<59, in_last=0: brojac++.
//     - brojac<59, in_last=1: short frame. Pulse greska, brojac=0, stay in PRIJEM.
//     - brojac==59, in_last=1: brojac=0, go to PUN. uzorak_valid=1 from the next cycle.
//     - brojac==59, in_last=0: long frame. Pulse greska, brojac=0, go to ODBACI.
//   State PUN: uzorak_valid=1, in_ready=0, uzorak frozen.
//     - out_ready=1: go to PRIJEM, broj_uzoraka++, uzorak_valid=0 next cycle.
//     - out_ready may be held high: completion-to-handover costs exactly 1 cycle in PUN.
//   State ODBACI: beats are accepted but dropped. A beat with in_last=1 returns to PRIJEM.
//   uzorak content is meaningful only while uzorak_valid=1. In PRIJEM it changes slot by slot.
//   Stale slots from an aborted frame are overwritten by the next frame.
//   Latency: last feature accepted in cycle N -> uzorak_valid=1 in cycle N+1.
//   Throughput: at most 1 sample per 61 cycles (60 beats + 1 PUN cycle).
//   greska is high for exactly the cycle after the offending beat. It never overlaps
//     uzorak_valid from the same frame.
//   brojac is 6 bits and never exceeds 59. Out-of-range values cannot occur.
//   State encoding is 2 bits: PRIJEM=0, PUN=1, ODBACI=2. Value 3 decodes to PRIJEM with brojac=0.
// STRUCTURE
//   Shared package (neuron_pkg): BROJ_ZNACAJKI, SIRINA_ZNACAJKE, SIRINA_UZORKA=960, and
//     the state encoding. These constants are also used by Neuron_1_FL and sibling neurons.
//   Single module, no sub-module: 6-bit counter, 2-bit FSM, 960-bit slot register
//     with per-slot write enable from brojac decode, 16-bit delivery counter.
// TESTING
//   1. Nominal: reset, stream features k=0..59 with in_data=k+1 and in_last on k=59, out_ready=1
//      -> uzorak[15:0]=1, uzorak[959:944]=60, uzorak_valid for 1 cycle, broj_uzoraka=1.
//   2. Backpressure: complete a frame with out_ready=0 for 10 cycles
//      -> uzorak_valid and uzorak stable, in_ready=0 throughout. Accept on out_ready=1.
//   3. Short frame: in_last on beat 10 -> greska pulse 1 cycle, no uzorak_valid.
//      The next full 60-beat frame is delivered correctly.
//   4. Long frame: 60 beats with no in_last, then 5 beats ending with in_last
//      -> greska once, 5 beats dropped, the following 60-beat frame is delivered correctly.
//   5. Reset mid-frame: rst_n=0 asynchronously after beat 30 -> all outputs 0 immediately.
//      A fresh 60-beat frame is assembled correctly.
//   6. Gapped input: in_valid toggled randomly over a 60-beat frame -> same uzorak as
//      scenario 1. Also check broj_uzoraka wraps 0xFFFF->0 (forced counter preload).

Source files
------------

// File: rtl/neuron_pkg.sv
// Constants and state encoding shared by the sample collector and the first-layer neurons.
package neuron_pkg;
  localparam int BROJ_ZNACAJKI   = 60;
  localparam int SIRINA_ZNACAJKE = 16;
  localparam int SIRINA_UZORKA   = BROJ_ZNACAJKI * SIRINA_ZNACAJKE;
  localparam int SIRINA_BROJACA  = 6;

  typedef enum logic [1:0] {
    PRIJEM = 2'd0,
    PUN    = 2'd1,
    ODBACI = 2'd2
  } stanje_e;
endpackage

// File: rtl/sakupljac_uzorka_if.sv
// Feature stream in, assembled sample out. Valid/ready: a transfer happens on a rising
// clk edge where valid && ready; the sender holds data stable while valid is high.
interface sakupljac_uzorka_if;
  import neuron_pkg::*;

  logic [SIRINA_ZNACAJKE-1:0] in_data;
  logic                       in_valid;
  logic                       in_last;
  logic                       in_ready;
  logic [SIRINA_UZORKA-1:0]   uzorak;
  logic                       uzorak_valid;
  logic                       out_ready;
  logic [1:0]                 stanje;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, uzorak, uzorak_valid, stanje
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, uzorak, uzorak_valid, stanje
  );
endinterface

// File: rtl/sakupljac_uzorka.sv
// Collects 60 features into a flat sample register and holds it until the classifier
// takes it; misframed samples raise greska and are discarded.
module sakupljac_uzorka
  import neuron_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  sakupljac_uzorka_if.slave          bus,
  output logic                       greska,
  output logic [SIRINA_ZNACAJKE-1:0] broj_uzoraka
);

  localparam logic [SIRINA_BROJACA-1:0] ZADNJI = SIRINA_BROJACA'(BROJ_ZNACAJKI - 1);

  stanje_e                      stanje_q, stanje_d, stanje_eff;
  logic [SIRINA_BROJACA-1:0]    brojac_q, brojac_d, brojac_eff;
  logic [SIRINA_UZORKA-1:0]     uzorak_q, uzorak_d;
  logic                         greska_q, greska_d;
  logic [SIRINA_ZNACAJKE-1:0]   broj_q, broj_d;
  logic                         in_ready;
  logic                         upis;

  // The unused encoding 3 behaves exactly like PRIJEM with an empty counter.
  always_comb begin
    stanje_eff = stanje_q;
    brojac_eff = brojac_q;
    if (!(stanje_q inside {PRIJEM, PUN, ODBACI})) begin
      stanje_eff = PRIJEM;
      brojac_eff = '0;
    end
  end

  assign in_ready = (stanje_eff == PRIJEM) || (stanje_eff == ODBACI);
  assign upis     = bus.in_valid && in_ready;

  always_comb begin
    stanje_d = stanje_eff;
    brojac_d = brojac_eff;
    uzorak_d = uzorak_q;
    greska_d = 1'b0;
    broj_d   = broj_q;
    case (stanje_eff)
      PRIJEM: begin
        if (upis) begin
          for (int k = 0; k < BROJ_ZNACAJKI; k++) begin
            if (brojac_eff == SIRINA_BROJACA'(k)) begin
              uzorak_d[k*SIRINA_ZNACAJKE +: SIRINA_ZNACAJKE] = bus.in_data;
            end
          end
          if (brojac_eff == ZADNJI) begin
            brojac_d = '0;
            if (bus.in_last) begin
              stanje_d = PUN;
            end else begin
              greska_d = 1'b1;
              stanje_d = ODBACI;
            end
          end else if (bus.in_last) begin
            greska_d = 1'b1;
            brojac_d = '0;
          end else begin
            brojac_d = brojac_eff + 1'b1;
          end
        end
      end
      PUN: begin
        if (bus.out_ready) begin
          stanje_d = PRIJEM;
          broj_d   = broj_q + 1'b1;
        end
      end
      ODBACI: begin
        if (upis && bus.in_last) begin
          stanje_d = PRIJEM;
        end
      end
      default: stanje_d = PRIJEM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stanje_q <= PRIJEM;
      brojac_q <= '0;
      uzorak_q <= '0;
      greska_q <= 1'b0;
      broj_q   <= '0;
    end else begin
      stanje_q <= stanje_d;
      brojac_q <= brojac_d;
      uzorak_q <= uzorak_d;
      greska_q <= greska_d;
      broj_q   <= broj_d;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.uzorak       = uzorak_q;
  assign bus.uzorak_valid = (stanje_q == PUN);
  assign bus.stanje       = stanje_q;
  assign greska           = greska_q;
  assign broj_uzoraka     = broj_q;

endmodule

// File: tb/tb_sakupljac_uzorka.sv
// Directed bench for sakupljac_uzorka: drivers push expected samples into a queue, a
// negedge monitor pops and compares on every accepted sample.
module tb_sakupljac_uzorka;
  import neuron_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        greska;
  logic [15:0] broj_uzoraka;

  sakupljac_uzorka_if bus ();

  sakupljac_uzorka dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus.slave),
    .greska       (greska),
    .broj_uzoraka (broj_uzoraka)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [SIRINA_UZORKA+15:0] exp_q[$];
  logic [15:0]               sb_cnt;
  int n_tests;
  int n_fail;
  int greska_cnt;
  int valid_cycles;

  task automatic check(input string name, input logic [SIRINA_UZORKA-1:0] act,
                       input logic [SIRINA_UZORKA-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (greska) begin
        greska_cnt++;
        check("greska_no_overlap", {959'd0, bus.uzorak_valid}, '0);
      end
      if (bus.uzorak_valid) valid_cycles++;
      if (bus.uzorak_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_sample", 960'd1, 960'd0);
        end else begin
          logic [SIRINA_UZORKA+15:0] e;
          e = exp_q.pop_front();
          check("uzorak", bus.uzorak, e[SIRINA_UZORKA-1:0]);
          check("broj_uzoraka_at_handover", {944'd0, broj_uzoraka},
                {944'd0, e[SIRINA_UZORKA+15:SIRINA_UZORKA]});
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic send_beat(input logic [15:0] d, input logic last, input bit gapped);
    int t;
    if (gapped) begin
      int idle;
      idle = $urandom_range(0, 2);
      for (int i = 0; i < idle; i++) @(negedge clk);
    end
    bus.in_data  = d;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    t = 0;
    while (!bus.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("in_ready_timeout", 960'd1, 960'd0);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic [15:0] base, input bit last_at_end,
                            input bit gapped, input bit deliver,
                            output logic [SIRINA_UZORKA-1:0] exp_u);
    exp_u = '0;
    for (int k = 0; k < n; k++) exp_u[k*16 +: 16] = base + 16'(k);
    if (deliver) begin
      exp_q.push_back({sb_cnt, exp_u});
      sb_cnt = sb_cnt + 16'd1;
    end
    for (int k = 0; k < n; k++)
      send_beat(base + 16'(k), last_at_end && (k == n - 1), gapped);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || bus.uzorak_valid) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) check("drain_timeout", 960'd1, 960'd0);
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  logic [SIRINA_UZORKA-1:0] u1, u_tmp;
  int g0;

  initial begin
    n_tests = 0; n_fail = 0; greska_cnt = 0; valid_cycles = 0; sb_cnt = '0;
    bus.in_data = '0; bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_uzorak", bus.uzorak, '0);
    check("reset_valid", {959'd0, bus.uzorak_valid}, '0);
    check("reset_greska", {959'd0, greska}, '0);
    check("reset_broj", {944'd0, broj_uzoraka}, '0);
    check("reset_in_ready", {959'd0, bus.in_ready}, 960'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // 1. nominal, out_ready held high
    send_frame(60, 16'd1, 1'b1, 1'b0, 1'b1, u1);
    check("latency_valid", {959'd0, bus.uzorak_valid}, 960'd1);
    check("slot0", {944'd0, bus.uzorak[15:0]}, 960'd1);
    check("slot59", {944'd0, bus.uzorak[959:944]}, 960'd60);
    @(negedge clk);
    check("valid_one_cycle", {959'd0, bus.uzorak_valid}, '0);
    wait_idle();
    check("valid_cycles", 960'(valid_cycles), 960'd1);
    check("broj_after_1", {944'd0, broj_uzoraka}, 960'd1);

    // 2. backpressure
    bus.out_ready = 1'b0;
    send_frame(60, 16'd100, 1'b1, 1'b0, 1'b1, u_tmp);
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", {959'd0, bus.uzorak_valid}, 960'd1);
      check("bp_in_ready", {959'd0, bus.in_ready}, '0);
      check("bp_stable", bus.uzorak, u_tmp);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    wait_idle();
    check("broj_after_2", {944'd0, broj_uzoraka}, 960'd2);

    // 3. short frame, then a good one
    g0 = greska_cnt;
    send_frame(11, 16'h0200, 1'b1, 1'b0, 1'b0, u_tmp);
    repeat (2) @(negedge clk);
    check("short_greska", 960'(greska_cnt - g0), 960'd1);
    check("short_no_valid", {959'd0, bus.uzorak_valid}, '0);
    send_frame(60, 16'h0300, 1'b1, 1'b0, 1'b1, u_tmp);
    wait_idle();

    // 4. long frame, dropped tail, then a good one
    g0 = greska_cnt;
    send_frame(60, 16'h0400, 1'b0, 1'b0, 1'b0, u_tmp);
    check("long_state_odbaci", {958'd0, bus.stanje}, 960'd2);
    send_frame(5, 16'hDEA0, 1'b1, 1'b0, 1'b0, u_tmp);
    check("long_back_prijem", {958'd0, bus.stanje}, '0);
    check("long_greska", 960'(greska_cnt - g0), 960'd1);
    send_frame(60, 16'h0500, 1'b1, 1'b0, 1'b1, u_tmp);
    wait_idle();
    check("broj_after_4", {944'd0, broj_uzoraka}, 960'd4);

    // 5. asynchronous reset mid-frame
    send_frame(31, 16'h0700, 1'b0, 1'b0, 1'b0, u_tmp);
    #2 rst_n = 1'b0;
    #1;
    check("arst_uzorak", bus.uzorak, '0);
    check("arst_valid", {959'd0, bus.uzorak_valid}, '0);
    check("arst_broj", {944'd0, broj_uzoraka}, '0);
    check("arst_greska", {959'd0, greska}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    sb_cnt = '0;
    @(negedge clk);
    send_frame(60, 16'h0600, 1'b1, 1'b0, 1'b1, u_tmp);
    wait_idle();

    // 6. gapped input gives the same sample as scenario 1; then counter wrap
    send_frame(60, 16'd1, 1'b1, 1'b1, 1'b1, u_tmp);
    wait_idle();
    force dut.broj_q = 16'hFFFF;
    #1 release dut.broj_q;
    @(negedge clk);
    check("preload_broj", {944'd0, broj_uzoraka}, 960'hFFFF);
    sb_cnt = 16'hFFFF;
    send_frame(60, 16'd1, 1'b1, 1'b1, 1'b1, u_tmp);
    wait_idle();
    check("broj_wrap", {944'd0, broj_uzoraka}, '0);

    check("greska_total", 960'(greska_cnt), 960'd2);
    check("queue_empty", 960'(exp_q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, expected completion");
    $fatal(1);
  end

endmodule
